// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bi, one bit per clock, LSB first, using a
// single full-subtractor cell and a borrow flop, with a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic diff_bit;
  logic br_next;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    diff_bit = sa[0] ^ sb[0] ^ br;
    br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      bo    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bi;
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= {diff_bit, sr[WIDTH-1:1]};
          br  <= br_next;
          cnt <= cnt + 1'b1;
          // Result registers only move on the final bit, so d/bo hold the old value meanwhile.
          if (cnt == LAST) begin
            d     <= {diff_bit, sr[WIDTH-1:1]};
            bo    <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4) against an arithmetic
// reference model: d = (a-b-bi) mod 16, bo = (a < b+bi).
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bi;
  logic [W-1:0] d;
  logic         bo;
  logic         busy;
  logic         done;

  int checks = 0;
  int passed = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bi   (bi),
    .d    (d),
    .bo   (bo),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] four_bit_adder(input logic [3:0] x, input logic [3:0] y,
                                                input logic ci);
    return {1'b0, x} + {1'b0, y} + {4'b0, ci};
  endfunction

  function automatic logic [3:0] ref_d(input int x, input int y, input int ci);
    return 4'((x - y - ci) & 15);
  endfunction

  function automatic logic ref_bo(input int x, input int y, input int ci);
    return (x < y + ci);
  endfunction

  // Launch one operation from IDLE, wait for done (bounded), then step back to IDLE.
  task automatic do_op(input logic [3:0] av, input logic [3:0] bv, input logic biv,
                       output logic [3:0] dd, output logic bb, output int lat,
                       output int busy_cnt, output bit timeout);
    a = av; b = bv; bi = biv; start = 1'b1;
    tick();
    start = 1'b0;
    a = 4'($urandom); b = 4'($urandom); bi = 1'($urandom);
    lat = 0; busy_cnt = 0; timeout = 0;
    while (!done && lat < 20) begin
      busy_cnt += int'(busy);
      tick();
      lat++;
    end
    if (!done) timeout = 1;
    dd = d; bb = bo;
    $display("op a=%0d b=%0d bi=%0d -> d=%0d bo=%0d lat=%0d", av, bv, biv, dd, bb, lat);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
    tick(); tick();
    checks++;
    if ({d, bo, busy, done} !== 7'b0)
      $display("FAIL reset_state got d=%0d bo=%b busy=%b done=%b want all 0", d, bo, busy, done);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] dd; logic bb; int lat, bc; bit to;
    do_op(4'd5, 4'd3, 1'b0, dd, bb, lat, bc, to);
    checks++;
    if (to || lat != 4) $display("FAIL basic_latency got %0d want 4 (timeout=%0d)", lat, to);
    else passed++;
    checks++;
    if (bc != 4) $display("FAIL basic_busy_cycles got %0d want 4", bc);
    else passed++;
    checks++;
    if (dd !== 4'd2 || bb !== 1'b0) $display("FAIL basic_result got d=%0d bo=%b want d=2 bo=0", dd, bb);
    else passed++;
    checks++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse got done=%b want 0 one cycle later", done);
    else passed++;
  endtask

  task automatic test_corners();
    logic [3:0] av [3] = '{4'd3, 4'd0, 4'd15};
    logic [3:0] bv [3] = '{4'd5, 4'd0, 4'd15};
    logic       cv [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0] dw [3] = '{4'd14, 4'd15, 4'd0};
    logic       bw [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0] dd; logic bb; int lat, bc; bit to;
    for (int i = 0; i < 3; i++) begin
      do_op(av[i], bv[i], cv[i], dd, bb, lat, bc, to);
      checks++;
      if (to || dd !== dw[i] || bb !== bw[i])
        $display("FAIL corner_%0d got d=%0d bo=%b want d=%0d bo=%b", i, dd, bb, dw[i], bw[i]);
      else passed++;
    end
  endtask

  task automatic test_sweep();
    logic [3:0] dd; logic bb; int lat, bc; bit to;
    logic [4:0] s;
    for (int x = 0; x < 512; x++) begin
      logic [3:0] av, bv; logic cv;
      av = 4'(x >> 5); bv = 4'(x >> 1); cv = 1'(x);
      do_op(av, bv, cv, dd, bb, lat, bc, to);
      checks++;
      if (to || dd !== ref_d(av, bv, cv) || bb !== ref_bo(av, bv, cv))
        $display("FAIL sweep a=%0d b=%0d bi=%0d got d=%0d bo=%b want d=%0d bo=%b",
                 av, bv, cv, dd, bb, ref_d(av, bv, cv), ref_bo(av, bv, cv));
      else passed++;
      s = four_bit_adder(dd, bv, cv);
      checks++;
      if (s[3:0] !== av || s[4] !== bb)
        $display("FAIL sweep_adder_xcheck a=%0d b=%0d bi=%0d got sum=%0d carry=%b want sum=%0d carry=%b",
                 av, bv, cv, s[3:0], s[4], av, bb);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ah [30];
    logic [3:0] bh [30];
    logic       ch [30];
    int n_done = 0;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ah[i] = 4'($urandom); bh[i] = 4'($urandom); ch[i] = 1'($urandom);
      a = ah[i]; b = bh[i]; bi = ch[i];
      tick();
      checks++;
      if (done !== ((i % 6) == 4))
        $display("FAIL b2b_done_timing cycle=%0d got done=%b want %b", i, done, (i % 6) == 4);
      else passed++;
      if (done && i >= 4) begin
        n_done++;
        checks++;
        if (d !== ref_d(ah[i-4], bh[i-4], ch[i-4]) || bo !== ref_bo(ah[i-4], bh[i-4], ch[i-4]))
          $display("FAIL b2b_result cycle=%0d got d=%0d bo=%b want d=%0d bo=%b", i, d, bo,
                   ref_d(ah[i-4], bh[i-4], ch[i-4]), ref_bo(ah[i-4], bh[i-4], ch[i-4]));
        else passed++;
        $display("b2b a=%0d b=%0d bi=%0d -> d=%0d bo=%0d", ah[i-4], bh[i-4], ch[i-4], d, bo);
      end
    end
    start = 1'b0;
    tick();
    checks++;
    if (n_done != 5) $display("FAIL b2b_count got %0d want 5", n_done);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] dd; logic bb; int lat, bc; bit to;
    int spurious = 0;
    a = 4'd9; b = 4'd4; bi = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({d, bo, busy, done} !== 7'b0)
      $display("FAIL reset_mid_async got d=%0d bo=%b busy=%b done=%b want all 0", d, bo, busy, done);
    else passed++;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) spurious++;
    end
    checks++;
    if (spurious != 0) $display("FAIL reset_mid_no_done got %0d active cycles want 0", spurious);
    else passed++;
    do_op(4'd9, 4'd4, 1'b0, dd, bb, lat, bc, to);
    checks++;
    if (to || dd !== 4'd5 || bb !== 1'b0)
      $display("FAIL reset_mid_recover got d=%0d bo=%b want d=5 bo=0", dd, bb);
    else passed++;
  endtask

  task automatic test_hold();
    logic [3:0] dd; logic bb; int lat, bc; bit to;
    int bad_hold = 0;
    int n = 0;
    do_op(4'd5, 4'd3, 1'b0, dd, bb, lat, bc, to);
    a = 4'd8; b = 4'd1; bi = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; a = 4'd0; b = 4'd0;
    while (!done && n < 20) begin
      if (d !== 4'd2) bad_hold++;
      tick();
      n++;
    end
    checks++;
    if (bad_hold != 0 || n != 4) $display("FAIL hold_prev got %0d bad cycles, lat=%0d want 0, 4", bad_hold, n);
    else passed++;
    checks++;
    if (!done || d !== 4'd7 || bo !== 1'b0)
      $display("FAIL hold_new got d=%0d bo=%b done=%b want d=7 bo=0 done=1", d, bo, done);
    else passed++;
    $display("hold a=8 b=1 bi=0 -> d=%0d bo=%0d", d, bo);
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_sweep();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor computing d = a − b − bi over WIDTH clock cycles using a single full-subtractor cell and a borrow flip-flop. It is the inverse of the team's ripple-carry full-adder datapath: for every operand set, a = d + b + bi (mod 2^WIDTH) with the carry-out equal to bo. It sits beside the adder as a low-area arithmetic unit, with a start/busy/done handshake to its controller.

## Interface
- WIDTH, 4, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high; resets all state immediately
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured at accepted start
- b  input  WIDTH  subtrahend; captured at accepted start
- bi  input  1  borrow-in; captured at accepted start
- d  output  WIDTH  difference; registered; holds last result
- bo  output  1  borrow-out, 1 when a < b + bi; registered; holds last result
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE; d and bo are valid from this cycle on

## Operation
- States: IDLE, RUN, DONE. The reset state is IDLE.
- IDLE: if start=1 at the clock edge, capture a and b into shift registers sa and sb, load the borrow flop br with bi, clear the bit counter, and go to RUN. If start=0, remain in IDLE.
- RUN, one bit per edge, LSB first:
  - bit = sa[0] ^ sb[0] ^ br
  - br ← (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)
  - sa and sb shift right
  - bit enters the MSB of the internal result shift register sr, which shifts right
  - the counter increments
- On the WIDTH-th RUN edge: d ← final sr, bo ← final br, and the state moves to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE unconditionally.
- start is ignored in RUN and DONE; there is no queuing.
- Input changes on a, b and bi after capture have no effect on the result in progress.
- d and bo change only on the completion edge, so they stay stable and show the previous result while a new operation runs.
- Arithmetic is modulo 2^WIDTH. bo is the true borrow, independent of any sign interpretation.
- The counter width is clog2(WIDTH)+1 bits. There is no wrap-around inside an operation.
- Reset when asserted, including mid-operation: state=IDLE, d=0, bo=0, busy=0, done=0, and sa, sb, sr, br and the counter are all cleared. The partial result is discarded and no done pulse follows.
- Reset deassertion takes effect at the first clock edge after release. start sampled at that edge is accepted if high.

## Timing
- Reset values: d=0, bo=0, busy=0, done=0.
- Latency is defined relative to edge k, the edge that accepts start:
  - busy is high during the cycles after edges k … k+WIDTH−1.
  - d, bo and done update at edge k+WIDTH. done is high for that cycle only.
  - IDLE is re-entered at edge k+WIDTH+1.
- Throughput: with start held high, a new operation is accepted every WIDTH+2 cycles (edges k, k+WIDTH+2, …).
- There is no combinational path from any input to any output.

## Test plan
- WIDTH=4, a=5, b=3, bi=0, one-cycle start -> done exactly 4 edges after acceptance; d=2, bo=0; busy high for 4 cycles.
- a=3, b=5, bi=0 -> d=14, bo=1. Then a=0, b=0, bi=1 -> d=15, bo=1. Then a=15, b=15, bi=0 -> d=0, bo=0.
- Exhaustive sweep of all 512 {a,b,bi} combinations, each started after the previous done -> for every case d = (a−b−bi) mod 16, bo = (a < b+bi), and the fourbitAdder cross-check fourbitAdder(d, b, bi) returns sum=a, carry=bo.
- start held high with operands changing every cycle -> acceptances spaced 6 cycles apart; each result matches the operands present on its accepting edge; start and operand changes during RUN and DONE have no effect.
- Assert rst two edges into RUN (a=9, b=4) -> d=0, bo=0, busy=0 and done=0 immediately, with no done pulse afterwards. After release, a new start with a=9, b=4 gives d=5, bo=0.
- Previous result d=2 is held, then a new operation a=8, b=1 runs -> d reads 2 throughout RUN and changes to 7 only on the done cycle.
